sump_cmd_decoder: RTL and testbench

Receives bytes from the UART receiver and decodes SUMP/OLS host commands. Short commands (opcode < 0x80) become strobes. Long commands (opcode ≥ 0x80 plus 4 data bytes) are assembled into an opcode/32-bit data word. The block drives begin_meta_transmit and send_id into metadata_sender and holds each request until metadata_sender acknowledges it through meta_busy.

---
 rtl/sump_pkg.sv | 12 +
 rtl/sump_meta_req.sv | 40 ++++
 rtl/sump_cmd_decoder.sv | 103 ++++++++++
 tb/tb_sump_cmd_decoder.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/sump_pkg.sv
// sump_pkg: SUMP/OLS opcode constants and decoder state encodings.
package sump_pkg;
  localparam logic [7:0] OP_RESET      = 8'h00;
  localparam logic [7:0] OP_ARM        = 8'h01;
  localparam logic [7:0] OP_ID         = 8'h02;
  localparam logic [7:0] OP_META       = 8'h04;
  localparam logic [7:0] OP_XON        = 8'h11;
  localparam logic [7:0] OP_XOFF       = 8'h13;
  localparam logic [7:0] LONG_CMD_MASK = 8'h80;
  typedef enum logic {P_IDLE, P_COLLECT} parser_state_t;
  typedef enum logic [1:0] {M_IDLE, M_REQ, M_WAIT} meta_state_t;
endpackage

// File: rtl/sump_meta_req.sv
// sump_meta_req: holds one metadata/ID request until metadata_sender acknowledges it via meta_busy.
module sump_meta_req
  import sump_pkg::*;
(
  input  logic clock,
  input  logic reset_n,
  input  logic req,
  input  logic req_id,
  input  logic cancel,
  input  logic meta_busy,
  output logic begin_meta_transmit,
  output logic send_id,
  output logic drop
);
  meta_state_t state, state_nx;
  logic id_nx;
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state   <= M_IDLE;
      send_id <= 1'b0;
    end else begin
      state   <= state_nx;
      send_id <= id_nx;
    end
  end
  always_comb begin
    state_nx = state;
    id_nx = send_id;
    drop = req && state != M_IDLE;
    begin_meta_transmit = state == M_REQ;
    case (state)
      M_IDLE: if (req) begin
        state_nx = M_REQ;
        id_nx = req_id;
      end
      M_REQ: state_nx = cancel ? M_IDLE : meta_busy ? M_WAIT : M_REQ;
      default: if (!meta_busy) state_nx = M_IDLE;
    endcase
  end
endmodule

// File: rtl/sump_cmd_decoder.sv
// sump_cmd_decoder: decodes SUMP/OLS host bytes into strobes, long commands and metadata requests.
// Define SUMP_DECODER_ERR_CNT_EN to add the saturating err_count output.
module sump_cmd_decoder
  import sump_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic [7:0]  rx_byte,
  input  logic        rx_valid,
  input  logic        meta_busy,
  output logic        begin_meta_transmit,
  output logic        send_id,
  output logic        soft_reset,
  output logic        arm,
  output logic        cmd_valid,
  output logic [7:0]  cmd_opcode,
  output logic [31:0] cmd_data,
  output logic        decoder_busy
`ifdef SUMP_DECODER_ERR_CNT_EN
  ,
  output logic [7:0]  err_count
`endif
);
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  parser_state_t state, state_nx;
  logic [1:0] idx;
  logic [7:0] op_q;
  logic [23:0] shadow;
  logic [CW-1:0] cnt;
  logic rx_idle, rx_coll, is_long, last, timeout, req, cancel, bad_op, drop;
  assign rx_idle = rx_valid && state == P_IDLE;
  assign rx_coll = rx_valid && state == P_COLLECT;
  assign is_long = (rx_byte & LONG_CMD_MASK) != 8'h00;
  assign last = rx_coll && idx == 2'd3;
  assign timeout = state == P_COLLECT && !rx_valid && cnt == CW'(TIMEOUT_CYCLES);
  assign req = rx_idle && (rx_byte == OP_ID || rx_byte == OP_META);
  assign cancel = rx_idle && rx_byte == OP_RESET;
  assign bad_op = rx_idle && !is_long &&
                  !(rx_byte inside {OP_RESET, OP_ARM, OP_ID, OP_META, OP_XON, OP_XOFF});
  assign decoder_busy = state == P_COLLECT;
  always_comb begin
    state_nx = state;
    if (rx_idle && is_long) state_nx = P_COLLECT;
    else if (last || timeout) state_nx = P_IDLE;
  end
  // The first three data bytes shift in from the top, so the fourth completes the word directly.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state      <= P_IDLE;
      idx        <= 2'd0;
      op_q       <= 8'h00;
      shadow     <= 24'h0;
      cnt        <= '0;
      soft_reset <= 1'b0;
      arm        <= 1'b0;
      cmd_valid  <= 1'b0;
      cmd_opcode <= 8'h00;
      cmd_data   <= 32'h0;
    end else begin
      state      <= state_nx;
      soft_reset <= cancel;
      arm        <= rx_idle && rx_byte == OP_ARM;
      cmd_valid  <= last;
      cnt        <= (rx_valid || timeout || state != P_COLLECT) ? '0 : cnt + CW'(1);
      if (rx_idle && is_long) begin
        op_q <= rx_byte;
        idx  <= 2'd0;
      end else if (rx_coll) begin
        idx    <= idx + 2'd1;
        shadow <= {rx_byte, shadow[23:8]};
      end else if (timeout) begin
        shadow <= 24'h0;
      end
      if (last) begin
        cmd_opcode <= op_q;
        cmd_data   <= {rx_byte, shadow};
      end
    end
  end
  sump_meta_req u_meta (
    .clock               (clock),
    .reset_n             (reset_n),
    .req                 (req),
    .req_id              (rx_byte == OP_ID),
    .cancel              (cancel),
    .meta_busy           (meta_busy),
    .begin_meta_transmit (begin_meta_transmit),
    .send_id             (send_id),
    .drop                (drop)
  );
`ifdef SUMP_DECODER_ERR_CNT_EN
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) err_count <= 8'h00;
    else if (cancel) err_count <= 8'h00;
    else if ((bad_op || timeout || drop) && err_count != 8'hFF) err_count <= err_count + 8'd1;
  end
`else
  logic unused_err;
  assign unused_err = bad_op | timeout | drop;
`endif
endmodule

// File: tb/tb_sump_cmd_decoder.sv
// tb_sump_cmd_decoder: directed stimulus with an event scoreboard for sump_cmd_decoder.
module tb_sump_cmd_decoder;
  localparam int TO = 20;
  localparam int K_SRST = 1, K_ARM = 2, K_CMD = 3, K_META = 4;
  typedef struct {
    int          kind;
    logic [7:0]  op;
    logic [31:0] data;
  } ev_t;
  logic clock = 1'b0;
  logic reset_n = 1'b0;
  logic [7:0] rx_byte = 8'h00;
  logic rx_valid = 1'b0;
  logic meta_busy = 1'b0;
  logic begin_meta_transmit, send_id, soft_reset, arm, cmd_valid, decoder_busy;
  logic [7:0] cmd_opcode;
  logic [31:0] cmd_data;
`ifdef SUMP_DECODER_ERR_CNT_EN
  logic [7:0] err_count;
`endif
  ev_t q[$];
  int tests = 0, fails = 0;
  logic bmt_q = 1'b0;
  sump_cmd_decoder #(.TIMEOUT_CYCLES(TO)) dut (
    .clock               (clock),
    .reset_n             (reset_n),
    .rx_byte             (rx_byte),
    .rx_valid            (rx_valid),
    .meta_busy           (meta_busy),
    .begin_meta_transmit (begin_meta_transmit),
    .send_id             (send_id),
    .soft_reset          (soft_reset),
    .arm                 (arm),
    .cmd_valid           (cmd_valid),
    .cmd_opcode          (cmd_opcode),
    .cmd_data            (cmd_data),
    .decoder_busy        (decoder_busy)
`ifdef SUMP_DECODER_ERR_CNT_EN
    ,
    .err_count           (err_count)
`endif
  );
  always #5 clock = ~clock;
  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask
  task automatic check_err(string name, logic [7:0] exp);
`ifdef SUMP_DECODER_ERR_CNT_EN
    check(name, 64'(err_count), 64'(exp));
`endif
  endtask
  task automatic expect_ev(int k, logic [7:0] o, logic [31:0] d);
    ev_t e;
    e.kind = k;
    e.op = o;
    e.data = d;
    q.push_back(e);
  endtask
  task automatic observe(int k, logic [7:0] o, logic [31:0] d);
    ev_t e;
    if (q.size() == 0) begin
      tests++;
      fails++;
      $display("FAIL unexpected_event: got kind %0d op %h data %h, expected none", k, o, d);
    end else begin
      e = q.pop_front();
      check("event_kind", 64'(k), 64'(e.kind));
      check("event_payload", {24'h0, o, d}, {24'h0, e.op, e.data});
    end
  endtask
  // Monitor: every strobe and each rising request edge must match the next expected event.
  always @(negedge clock) begin
    if (reset_n) begin
      if (soft_reset) observe(K_SRST, 8'h00, 32'h0);
      if (arm) observe(K_ARM, 8'h00, 32'h0);
      if (cmd_valid) observe(K_CMD, cmd_opcode, cmd_data);
      if (begin_meta_transmit && !bmt_q) observe(K_META, {7'h0, send_id}, 32'h0);
    end
    bmt_q = begin_meta_transmit;
  end
  task automatic send(logic [7:0] b);
    rx_byte = b;
    rx_valid = 1'b1;
    @(negedge clock);
    rx_valid = 1'b0;
  endtask
  task automatic idle(int n);
    repeat (n) @(negedge clock);
  endtask
  task automatic check_zero(string name);
    check(name, {begin_meta_transmit, send_id, soft_reset, arm, cmd_valid, decoder_busy,
                 cmd_opcode, cmd_data}, 64'h0);
    check_err({name, "_err"}, 8'h00);
  endtask
  initial begin
    idle(3);
    check_zero("reset_state");
    reset_n = 1'b1;
    idle(1);
    // ID request held until meta_busy is seen
    expect_ev(K_META, 8'h01, 32'h0);
    send(8'h02);
    check("id_req_begin", 64'(begin_meta_transmit), 64'd1);
    check("id_req_send_id", 64'(send_id), 64'd1);
    idle(2);
    meta_busy = 1'b1;
    check("id_req_held", 64'(begin_meta_transmit), 64'd1);
    idle(1);
    check("id_req_drop_after_busy", 64'(begin_meta_transmit), 64'd0);
    meta_busy = 1'b0;
    idle(1);
    // Metadata request while busy, then a dropped ID request
    meta_busy = 1'b1;
    expect_ev(K_META, 8'h00, 32'h0);
    send(8'h04);
    check("meta_req_begin", 64'(begin_meta_transmit), 64'd1);
    check("meta_req_send_id", 64'(send_id), 64'd0);
    idle(1);
    send(8'h02);
    check("dropped_req_begin", 64'(begin_meta_transmit), 64'd0);
    check("dropped_req_send_id", 64'(send_id), 64'd0);
    check_err("dropped_req_err", 8'd1);
    meta_busy = 1'b0;
    idle(2);
    // Full long command
    expect_ev(K_CMD, 8'hC0, 32'h12345678);
    send(8'hC0);
    check("long_busy", 64'(decoder_busy), 64'd1);
    send(8'h78);
    send(8'h56);
    send(8'h34);
    check("long_busy_mid", 64'(decoder_busy), 64'd1);
    send(8'h12);
    check("long_busy_done", 64'(decoder_busy), 64'd0);
    idle(2);
    // Partial command timeout
    send(8'h81);
    send(8'hAA);
    idle(TO);
    check("timeout_edge_busy", 64'(decoder_busy), 64'd1);
    idle(1);
    check("timeout_busy", 64'(decoder_busy), 64'd0);
    check("timeout_keeps_cmd", {24'h0, cmd_opcode, cmd_data}, {24'h0, 8'hC0, 32'h12345678});
    check_err("timeout_err", 8'd2);
    expect_ev(K_ARM, 8'h00, 32'h0);
    send(8'h01);
    idle(1);
    // Byte arriving on the timeout cycle wins
    expect_ev(K_CMD, 8'h83, 32'h04030201);
    send(8'h83);
    send(8'h01);
    idle(TO);
    send(8'h02);
    check("byte_wins_busy", 64'(decoder_busy), 64'd1);
    send(8'h03);
    send(8'h04);
    check_err("byte_wins_err", 8'd2);
    idle(1);
    // Soft reset strobes, then 0x00 as long-command data
    repeat (5) begin
      expect_ev(K_SRST, 8'h00, 32'h0);
      send(8'h00);
    end
    check_err("soft_reset_clears_err", 8'd0);
    expect_ev(K_CMD, 8'h80, 32'h0);
    send(8'h80);
    repeat (4) send(8'h00);
    idle(1);
    // Soft reset cancels a pending request
    expect_ev(K_META, 8'h01, 32'h0);
    send(8'h02);
    expect_ev(K_SRST, 8'h00, 32'h0);
    send(8'h00);
    check("cancel_req", 64'(begin_meta_transmit), 64'd0);
    idle(1);
    // Unknown opcode counts, XON does not
    send(8'h05);
    check_err("unknown_op_err", 8'd1);
    send(8'h11);
    check_err("xon_no_err", 8'd1);
    // Asynchronous reset in the middle of a long command
    send(8'h90);
    send(8'h01);
    send(8'h02);
    reset_n = 1'b0;
    #1;
    check_zero("async_reset");
    idle(1);
    reset_n = 1'b1;
    idle(1);
    expect_ev(K_CMD, 8'h80, 32'h04030201);
    send(8'h80);
    send(8'h01);
    send(8'h02);
    send(8'h03);
    send(8'h04);
    idle(5);
    check("scoreboard_empty", 64'(q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
